dmem_responder: RTL and testbench

- Memory-side responder for the MEM stage's data-memory request interface: read enable, write enable, address, store data.
- Serves each request after a fixed, parameterised latency from a word-organised, flop-based backing store.
- Drives a stall output that holds the pipeline in MEM until the access completes.
- Checks every address for alignment and range, and reports violations with a one-cycle error pulse.

---
 rtl/dmem_pkg.sv | 35 +++
 rtl/dmem_store.sv | 37 +++
 rtl/dmem_responder.sv | 175 +++++++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and elaboration helpers for the data-memory responder.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res = res + 1;
         v   = v >> 1;
      end
      return res;
   endfunction

   function automatic bit latency_ok(input int lat);
      return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
   endfunction

endpackage

// File: rtl/dmem_store.sv
// Flop-based word store: one write port, one combinational read port,
// cleared to zero by reset.
import dmem_pkg::*;

module dmem_store #(
   parameter int WORD_LEN    = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int IDX_W       = clog2(DEPTH_WORDS)
) (
   input  logic                clk,
   input  logic                rst_b,
   input  logic                we,
   input  logic [IDX_W-1:0]    widx,
   input  logic [WORD_LEN-1:0] wdata,
   input  logic [IDX_W-1:0]    ridx,
   output logic [WORD_LEN-1:0] rdata
);

   logic [WORD_LEN-1:0] mem [DEPTH_WORDS];

   // Storage array with asynchronous clear.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   // Combinational read.
   always_comb begin
      rdata = mem[ridx];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store from the MEM stage, stalls
// the pipeline for LATENCY cycles, commits on the edge into RESP and pulses
// exactly one of rd_valid / wr_ack / err in the RESP cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no request in flight; a request here is latched, stall raised
//   WAIT  | counting down remaining stall cycles on latched request
//   RESP  | request completed; stall low, one result pulse, back to IDLE
import dmem_pkg::*;

module dmem_responder #(
   parameter int WORD_LEN    = 32,
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_rd_en,
   input  logic                req_wr_en,
   input  logic [WORD_LEN-1:0] req_addr,
   input  logic [WORD_LEN-1:0] req_wdata,
   output logic                stall,
   output logic [WORD_LEN-1:0] rd_data,
   output logic                rd_valid,
   output logic                wr_ack,
   output logic                err
);

   localparam int ADDR_W = clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

   if (!latency_ok(LATENCY)) begin : g_bad_latency
      $error("dmem_responder: LATENCY must be within 1..15");
   end

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   op_t                 op_q;
   logic [ADDR_W-1:0]   idx_q;
   logic [WORD_LEN-1:0] wdata_q;
   logic                err_q;

   logic                req;
   op_t                 in_op;
   logic [ADDR_W-1:0]   in_idx;
   logic                in_err;

   op_t                 cur_op;
   logic [ADDR_W-1:0]   cur_idx;
   logic [WORD_LEN-1:0] cur_wdata;
   logic                cur_err;

   logic                commit;
   logic                mem_we;
   logic [WORD_LEN-1:0] mem_rdata;

   // Request decode and address check on the live inputs. A request with
   // both enables set is classed as a (rejected) read, so rd_data clears.
   always_comb begin
      req    = req_rd_en | req_wr_en;
      in_op  = (req_wr_en && !req_rd_en) ? OP_WR : OP_RD;
      in_idx = req_addr[ADDR_W+1:2];
      in_err = (req_addr[1:0] != 2'b00)
             | ((req_addr >> (ADDR_W + 2)) != '0)
             | (req_rd_en & req_wr_en);
   end

   // Live inputs in IDLE (needed when LATENCY==1 commits on the accept
   // edge), latched copy otherwise.
   always_comb begin
      if (state_q == IDLE) begin
         cur_op    = in_op;
         cur_idx   = in_idx;
         cur_wdata = req_wdata;
         cur_err   = in_err;
      end else begin
         cur_op    = op_q;
         cur_idx   = idx_q;
         cur_wdata = wdata_q;
         cur_err   = err_q;
      end
   end

   // Next-state, counter and commit decision.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State register and down-counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request latch, captured only when a request is accepted in IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q    <= OP_RD;
         idx_q   <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
      end else if (state_q == IDLE && req) begin
         op_q    <= in_op;
         idx_q   <= in_idx;
         wdata_q <= req_wdata;
         err_q   <= in_err;
      end
   end

   assign mem_we = commit && (cur_op == OP_WR) && !cur_err;

   dmem_store #(
      .WORD_LEN    (WORD_LEN),
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (ADDR_W)
   ) u_store (
      .clk   (clk),
      .rst_b (rst),
      .we    (mem_we),
      .widx  (cur_idx),
      .wdata (cur_wdata),
      .ridx  (cur_idx),
      .rdata (mem_rdata)
   );

   // Load result register; only a completing read updates it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data <= '0;
      end else if (commit && cur_op == OP_RD) begin
         rd_data <= cur_err ? '0 : mem_rdata;
      end
   end

   // Stall and result pulses; stall is forced low while reset is held so
   // the pipeline is released the moment reset hits.
   always_comb begin
      stall    = rst & (((state_q == IDLE) & req) | (state_q == WAIT));
      rd_valid = (state_q == RESP) & (op_q == OP_RD) & ~err_q;
      wr_ack   = (state_q == RESP) & (op_q == OP_WR) & ~err_q;
      err      = (state_q == RESP) & err_q;
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2, DEPTH_WORDS=256).
module tb_dmem_responder;

   localparam int LAT = 2;

   logic        clk;
   logic        rst;
   logic        req_rd_en;
   logic        req_wr_en;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        wr_ack;
   logic        err;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   dmem_responder #(
      .WORD_LEN    (32),
      .DEPTH_WORDS (256),
      .LATENCY     (LAT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_rd_en (req_rd_en),
      .req_wr_en (req_wr_en),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .stall     (stall),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .wr_ack    (wr_ack),
      .err       (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exp_valid;
      logic        exp_ack;
      logic        exp_err;
      logic        chk_rdata;
      logic [31:0] exp_rdata;
   } vec_t;

   // Behavioural model state: word array and last load result.
   logic [31:0] m [256];
   logic [31:0] rd_model;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Drives one request starting just after a rising edge, follows it to
   // the RESP cycle and returns what was observed there. Returns just after
   // the edge into IDLE with the request inputs dropped.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, output int ns, output logic v,
                         output logic k, output logic e, output logic [31:0] q,
                         output logic stray, output int resp_cyc);
      bit done;
      req_rd_en = rd;
      req_wr_en = wr;
      req_addr  = a;
      req_wdata = d;
      ns    = 0;
      stray = 1'b0;
      done  = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (stall) begin
            ns++;
            if (rd_valid || wr_ack || err) stray = 1'b1;
         end else begin
            done = 1'b1;
         end
      end
      if (!done) ns = 99;
      v = rd_valid;
      k = wr_ack;
      e = err;
      q = rd_data;
      resp_cyc = cyc;
      @(posedge clk);
      #1;
      req_rd_en = 1'b0;
      req_wr_en = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input vec_t t);
      int ns, rc;
      logic v, k, e, stray;
      logic [31:0] q;
      do_req(t.rd, t.wr, t.addr, t.wdata, ns, v, k, e, q, stray, rc);
      chk({tag, " stall_cycles"}, 32'(ns), 32'(LAT));
      chk({tag, " rd_valid"}, 32'(v), 32'(t.exp_valid));
      chk({tag, " wr_ack"}, 32'(k), 32'(t.exp_ack));
      chk({tag, " err"}, 32'(e), 32'(t.exp_err));
      chk({tag, " early_pulse"}, 32'(stray), 32'd0);
      if (t.chk_rdata) chk({tag, " rd_data"}, q, t.exp_rdata);
   endtask

   initial begin
      vec_t tbl [8];
      int ns, rc1, rc2;
      logic v, k, e, stray;
      logic [31:0] q, val;

      rst       = 1'b0;
      req_rd_en = 1'b0;
      req_wr_en = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      for (int i = 0; i < 256; i++) m[i] = '0;
      rd_model = '0;

      tbl[0] = '{1'b1, 1'b0, 32'h0000_0004, 32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
      tbl[1] = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
      tbl[2] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
      tbl[3] = '{1'b0, 1'b1, 32'h0000_0012, 32'h0000_1234,  1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF};
      tbl[4] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
      tbl[5] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,          1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
      tbl[6] = '{1'b1, 1'b1, 32'h0000_0020, 32'h5555_AAAA,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[7] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          1'b1, 1'b0, 1'b0, 1'b1, 32'h0};

      // Reset state.
      #12;
      chk("reset stall", 32'(stall), 32'd0);
      chk("reset rd_valid", 32'(rd_valid), 32'd0);
      chk("reset wr_ack", 32'(wr_ack), 32'd0);
      chk("reset err", 32'(err), 32'd0);
      chk("reset rd_data", rd_data, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         run_and_check($sformatf("vec%0d", i), tbl[i]);
      end

      // Reset during WAIT of a write.
      req_wr_en = 1'b1;
      req_addr  = 32'h0000_0030;
      req_wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      chk("rstmid accept stall", 32'(stall), 32'd1);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      req_wr_en = 1'b0;
      #1;
      chk("rstmid stall", 32'(stall), 32'd0);
      chk("rstmid pulses", 32'({rd_valid, wr_ack, err}), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rstmid after pulses", 32'({rd_valid, wr_ack, err}), 32'd0);
      chk("rstmid after stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < 256; i++) m[i] = '0;
      rd_model = '0;
      do_req(1'b1, 1'b0, 32'h0000_0030, 32'h0, ns, v, k, e, q, stray, rc1);
      chk("rstmid readback rd_data", q, 32'h0);
      chk("rstmid readback rd_valid", 32'(v), 32'd1);

      // Back-to-back write then read of the same word.
      val = $urandom;
      do_req(1'b0, 1'b1, 32'h0000_0040, val, ns, v, k, e, q, stray, rc1);
      chk("b2b wr_ack", 32'(k), 32'd1);
      do_req(1'b1, 1'b0, 32'h0000_0040, 32'h0, ns, v, k, e, q, stray, rc2);
      chk("b2b rd_data", q, val);
      chk("b2b rd_valid", 32'(v), 32'd1);
      chk("b2b stall_cycles", 32'(ns), 32'(LAT));
      chk("b2b resp_spacing", 32'(rc2 - rc1), 32'(LAT + 1));
      @(negedge clk);
      chk("b2b no_reaccept stall", 32'(stall), 32'd0);
      chk("b2b no_reaccept pulses", 32'({rd_valid, wr_ack, err}), 32'd0);
      @(posedge clk);
      #1;
      m[16]    = val;
      rd_model = val;

      // Randomized requests against the model.
      for (int n = 0; n < 40; n++) begin
         int kind, idx, gap;
         logic rd, wr, xerr;
         logic [31:0] a, d;
         kind = int'($urandom_range(0, 9));
         idx  = int'($urandom_range(0, 255));
         rd   = $urandom_range(0, 1) == 1;
         wr   = !rd;
         d    = $urandom;
         a    = 32'(idx) << 2;
         if (kind == 0) a = a + 32'($urandom_range(1, 3));
         if (kind == 1) a = a | (32'd1 << $urandom_range(10, 31));
         xerr = (a[1:0] != 2'b00) || (a >= 32'h400);
         if (!xerr && wr) m[idx] = d;
         if (rd) rd_model = xerr ? 32'h0 : m[idx];
         do_req(rd, wr, a, d, ns, v, k, e, q, stray, rc1);
         chk($sformatf("rnd%0d stall_cycles", n), 32'(ns), 32'(LAT));
         chk($sformatf("rnd%0d pulses", n), 32'({v, k, e}),
             32'({rd && !xerr, wr && !xerr, xerr}));
         chk($sformatf("rnd%0d rd_data", n), q, rd_model);
         chk($sformatf("rnd%0d early_pulse", n), 32'(stray), 32'd0);
         gap = int'($urandom_range(0, 2));
         repeat (gap) begin
            @(posedge clk);
            #1;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
